// File: rtl/mem_model.sv
// Burst memory model: single-cycle request, fixed read latency with ready/valid beats,
// unthrottled write beats, sticky protocol-error flag. Storage is not cleared by reset.
module mem_model #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 32,
  parameter int MEM_DATA_BITS = 64,
  parameter int DEPTH_BITS    = 10,
  parameter int RD_LATENCY    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  input  logic                     mem_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
  input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  input  logic                     mem_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  output logic                     mem_rd_valid,
  output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  input  logic                     mem_rd_ready,
  output logic                     busy,
  output logic                     err
);

  localparam int BYTE_SHIFT = $clog2(MEM_DATA_BITS / 8);
  localparam int WORDS      = 2 ** DEPTH_BITS;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    READ_DATA  = 2'd2,
    WRITE_DATA = 2'd3
  } state_t;

  state_t                    state;
  logic [DEPTH_BITS-1:0]     ptr;
  logic [MEM_LEN_BITS-1:0]   remaining;
  logic [3:0]                lat;
  logic [DEPTH_BITS-1:0]     word_idx;
  logic                      accept;
  logic                      wr_en;
  logic                      unused_addr;

  logic [MEM_DATA_BITS-1:0]  mem [WORDS];

  // Byte-offset bits and address bits above the storage depth are dropped.
  assign word_idx    = mem_req_addr[BYTE_SHIFT +: DEPTH_BITS];
  assign unused_addr = ^mem_req_addr;

  assign accept = mem_req_valid && ((state == IDLE) || (state == WRITE_DATA));
  assign wr_en  = (state == WRITE_DATA) && mem_wr_valid;

  assign mem_rd_bits = mem[ptr];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[ptr] <= mem_wr_bits;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      remaining    <= '0;
      lat          <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      mem_rd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_wr_valid) begin
            err <= 1'b1;
          end
        end

        READ_WAIT: begin
          if (mem_req_valid || mem_wr_valid) begin
            err <= 1'b1;
          end
          if (lat <= 4'd1) begin
            lat          <= '0;
            state        <= READ_DATA;
            mem_rd_valid <= 1'b1;
          end else begin
            lat <= lat - 4'd1;
          end
        end

        READ_DATA: begin
          if (mem_req_valid || mem_wr_valid) begin
            err <= 1'b1;
          end
          if (mem_rd_ready) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == '0) begin
              state        <= IDLE;
              busy         <= 1'b0;
              mem_rd_valid <= 1'b0;
            end
          end
        end

        WRITE_DATA: begin
          if (mem_wr_valid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          mem_rd_valid <= 1'b0;
        end
      endcase

      // Placed after the case so a request in WRITE_DATA overrides the beat's
      // pointer/state update; the beat itself is still written via wr_en.
      if (accept) begin
        ptr       <= word_idx;
        remaining <= mem_req_len;
        busy      <= 1'b1;
        if (mem_req_opcode) begin
          state        <= WRITE_DATA;
          mem_rd_valid <= 1'b0;
        end else if (RD_LATENCY == 1) begin
          state        <= READ_DATA;
          mem_rd_valid <= 1'b1;
        end else begin
          state        <= READ_WAIT;
          lat          <= 4'(RD_LATENCY - 1);
          mem_rd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/mem_model.md
MEM_MODEL -- requirements
Module: mem_model

Interface
REQ-001 SHALL have parameter MEM_LEN_BITS, default 8, burst length field width (len = beats-1).
REQ-002 SHALL have parameter MEM_ADDR_BITS, default 32, byte address width.
REQ-003 SHALL have parameter MEM_DATA_BITS, default 64, beat width; bytes per word = MEM_DATA_BITS/8.
REQ-004 SHALL have parameter DEPTH_BITS, default 10, storage depth = 2^DEPTH_BITS words.
REQ-005 SHALL have parameter RD_LATENCY, default 2, cycles from read accept to first rd_valid (legal range 1..15).
REQ-006 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port mem_req_valid  in  1  request strobe, one cycle, no ready (always sampled).
REQ-009 SHALL have port mem_req_opcode  in  1  0 = read, 1 = write.
REQ-010 SHALL have port mem_req_len  in  MEM_LEN_BITS  beats-1.
REQ-011 SHALL have port mem_req_addr  in  MEM_ADDR_BITS  byte start address.
REQ-012 SHALL have port mem_wr_valid  in  1  write beat strobe, no backpressure.
REQ-013 SHALL have port mem_wr_bits  in  MEM_DATA_BITS  write beat data.
REQ-014 SHALL have port mem_rd_valid  out  1  read beat valid.
REQ-015 SHALL have port mem_rd_bits  out  MEM_DATA_BITS  read beat data.
REQ-016 SHALL have port mem_rd_ready  in  1  read beat accept.
REQ-017 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-018 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-019 SHALL implement states IDLE, READ_WAIT, READ_DATA, WRITE_DATA.
REQ-020 Word index SHALL be addr >> log2(MEM_DATA_BITS/8), truncated to DEPTH_BITS (wraps modulo depth); low byte-offset bits ignored.
REQ-021 IDLE + mem_req_valid: latch word pointer, remaining = len; opcode 0 -> READ_WAIT with latency counter = RD_LATENCY-1 (READ_DATA directly if RD_LATENCY=1); opcode 1 -> WRITE_DATA.
REQ-022 READ_WAIT SHALL count down to 0 then enter READ_DATA; mem_rd_valid low throughout.
REQ-023 READ_DATA: mem_rd_valid high, mem_rd_bits = word at pointer; data and valid held stable until mem_rd_ready.
REQ-024 On rd handshake: pointer+1 (wrapping), remaining-1; if remaining was 0 -> IDLE next cycle with mem_rd_valid low; burst of len+1 beats total.
REQ-025 WRITE_DATA: each mem_wr_valid cycle writes mem_wr_bits at pointer, pointer+1 (wrapping); beat with remaining = 0 -> IDLE.
REQ-026 New request accepted in the cycle immediately after returning to IDLE (zero-bubble back-to-back).
REQ-027 mem_req_valid in WRITE_DATA SHALL abandon remaining write beats and accept the new request as from IDLE, err unchanged (upstream write timeout recovery).
REQ-028 mem_req_valid in READ_WAIT/READ_DATA SHALL be dropped and set err.
REQ-029 mem_wr_valid outside WRITE_DATA SHALL be ignored (no write) and set err.
REQ-030 Simultaneous mem_wr_valid and mem_req_valid in WRITE_DATA: beat written first, then new request accepted.
REQ-031 Read of never-written word SHALL return whatever storage holds (no X-masking required); write-then-read of same word returns written data.
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 Reset low SHALL immediately force state IDLE, mem_rd_valid 0, busy 0, err 0, counters/pointer 0; storage contents unchanged.
REQ-034 Reset asserted mid-burst SHALL abandon the burst; no further writes or read beats after release until a new request.

Verification
REQ-035 Write addr 0x40 len 3, beats 0x11,0x22,0x33,0x44 -> words 8..11 written; then read addr 0x40 len 3, ready=1 -> first valid RD_LATENCY cycles after request, data 0x11,0x22,0x33,0x44, busy low cycle after last beat.
REQ-036 Read len 1 with mem_rd_ready toggling 1,0,0,1 -> each beat held stable while ready low; exactly 2 handshakes; err 0.
REQ-037 Write addr (2^DEPTH_BITS-1)*8 len 1, data A,B -> A at last word, B at word 0 (wrap); read-back confirms.
REQ-038 Write request len 7, only 2 beats, then new read request -> write abandoned, read accepted, err stays 0.
REQ-039 Read request then second request during READ_DATA, plus stray mem_wr_valid in IDLE -> second dropped, no write, err=1 sticky until reset.
REQ-040 Reset asserted during 4-beat read after beat 1 -> mem_rd_valid low immediately, busy 0, err 0; next read returns correct data.
